alu_writeback: RTL and testbench
================================

// Module: alu_writeback
// PURPOSE
//  Register-file and flag writeback stage downstream of the Alu block in the 16-bit CPU.
//  - Supplies operand1/operand2/carry to the Alu from an 8x16 register file.
//  - Captures the 17-bit Alu result into a one-deep writeback register.
//  - Commits the result to the register file and the C/Z/N flags one cycle later.
//  - Forwards pending values so back-to-back dependent ops see fresh data.
// PARAMETERS
//  REG_COUNT   8    register file depth; address width is clog2(REG_COUNT)=3
//  DATA_WIDTH  16   data width; result width is DATA_WIDTH+1 (bit 16 = carry out)
// PORTS
//  clk            in   1   single clock; all state updates on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  readAddr1      in   3   register index for operand1
//  readAddr2      in   3   register index for operand2
//  operand1       out  16  forwarded register value -> Alu operand1 (combinational)
//  operand2       out  16  forwarded register value -> Alu operand2 (combinational)
//  carry          out  1   forwarded C flag -> Alu carry (combinational)
//  result         in   17  Alu result; bit 16 = carry out
//  resultValid    in   1   result/destAddr/update* valid this cycle
//  destAddr       in   3   destination register
//  writeReg       in   1   commit result[15:0] to destAddr
//  updateFlags    in   1   commit Z and N
//  updateCarry    in   1   commit C
//  stall          in   1   hold the pending entry, no commit
//  inReady        out  1   !pendValid || !stall
//  carryFlag      out  1   architectural C
//  zeroFlag       out  1   architectural Z
//  negFlag        out  1   architectural N
//  overrunError   out  1   sticky; set when resultValid && !inReady
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - All registers = 0; carryFlag/zeroFlag/negFlag = 0.
//    - pendValid = 0, overrunError = 0.
//    - A pending entry is discarded, not committed.
//  - Capture: on an edge with resultValid && inReady, latch result, destAddr, writeReg,
//    updateFlags, updateCarry into the pending entry; pendValid <= 1.
//  - Commit: on an edge with pendValid && !stall:
//    - If writeReg: regs[destAddr] <= result[15:0].
//    - If updateFlags: Z <= (result[15:0]==0), N <= result[15].
//    - If updateCarry: C <= result[16].
//    - Then pendValid <= 0, unless a new capture happens on the same edge; capture and
//      commit on one edge are legal (throughput 1/cycle, latency 1 cycle to architectural state).
//  - Stall with pendValid: the entry and all architectural state are held.
//    - resultValid while !inReady: input ignored, overrunError <= 1 (sticky until reset).
//  - Stall with no pending entry: capture still allowed (inReady = 1).
//  - Forwarding (combinational):
//    - operandN = pending result[15:0] if pendValid && pend.writeReg && pend.destAddr == readAddrN,
//      else regs[readAddrN].
//    - carry = pend result[16] if pendValid && pend.updateCarry, else carryFlag.
//    - No forwarding from the un-captured result input (no combinational loop through the Alu).
//  - Same destAddr on consecutive ops: the newer pending entry wins the forward; the older
//    entry commits first, so final state is the newer value.
//  - Flag-only ops (writeReg=0) never alter registers. With writeReg=updateFlags=updateCarry=0,
//    an op is a pipeline bubble.
//  - All register indices 0..7 are general purpose; there is no hardwired zero register.
// TESTING
//  1. Reset, then readAddr1=0..7 -> operand1=0x0000 each; carry=0, zeroFlag=0, inReady=1.
//  2. Capture result=0x10243, dest=3, all updates=1:
//     - Next cycle: readAddr1=3 -> operand1=0x0243 (forwarded), carry=1.
//     - Cycle after: regs[3]=0x0243, C=1, Z=0, N=0.
//  3. Back-to-back captures 0x08234 -> R1, then 0x00000 -> R1 (flags on):
//     - Operand1 on R1 reads 0x8234, then 0x0000.
//     - Final R1=0x0000, Z=1, N=0, C=0.
//  4. Capture 0x1C11A -> R2, stall=1 for 3 cycles:
//     - regs[2] and flags unchanged; inReady=0.
//     - resultValid pulse during stall -> overrunError=1, pending stays 0x1C11A.
//     - Release stall -> regs[2]=0xC11A, N=1, C=1.
//  5. Capture 0x07DCA -> R5 with writeReg=1, updateFlags=0, updateCarry=0:
//     - regs[5]=0x7DCA; C/Z/N unchanged from the prior op.
//  6. Capture 0x1046B -> R4, assert rst_n=0 mid-pending:
//     - Immediately operand(R4)=0, carry=0, overrunError=0.
//     - After release, regs[4]=0.

Source files
------------

// File: rtl/alu_writeback.sv
// Writeback stage behind the Alu: 8x16 register file, C/Z/N flags and a one-deep
// pending entry with forwarding, so dependent back-to-back ops see fresh values.
module alu_writeback #(
  parameter int REG_COUNT  = 8,
  parameter int DATA_WIDTH = 16,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AW-1:0]         readAddr1,
  input  logic [AW-1:0]         readAddr2,
  output logic [DATA_WIDTH-1:0] operand1,
  output logic [DATA_WIDTH-1:0] operand2,
  output logic                  carry,
  input  logic [DATA_WIDTH:0]   result,
  input  logic                  resultValid,
  input  logic [AW-1:0]         destAddr,
  input  logic                  writeReg,
  input  logic                  updateFlags,
  input  logic                  updateCarry,
  input  logic                  stall,
  output logic                  inReady,
  output logic                  carryFlag,
  output logic                  zeroFlag,
  output logic                  negFlag,
  output logic                  overrunError
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  logic                  pendValid;
  logic [DATA_WIDTH:0]   pendResult;
  logic [AW-1:0]         pendDest;
  logic                  pendWriteReg;
  logic                  pendUpdateFlags;
  logic                  pendUpdateCarry;

  logic                  capture;
  logic                  commit;
  logic [REG_COUNT-1:0]  regWrEn;

  assign inReady = !pendValid || !stall;
  assign capture = resultValid && inReady;
  assign commit  = pendValid && !stall;

  // Per-register write enable from the pending destination address
  always_comb begin
    regWrEn = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      regWrEn[i] = commit && pendWriteReg && (pendDest == AW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendValid       <= 1'b0;
      pendResult      <= '0;
      pendDest        <= '0;
      pendWriteReg    <= 1'b0;
      pendUpdateFlags <= 1'b0;
      pendUpdateCarry <= 1'b0;
    end else if (capture) begin
      pendValid       <= 1'b1;
      pendResult      <= result;
      pendDest        <= destAddr;
      pendWriteReg    <= writeReg;
      pendUpdateFlags <= updateFlags;
      pendUpdateCarry <= updateCarry;
    end else if (commit) begin
      pendValid       <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (regWrEn[i]) regs[i] <= pendResult[DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carryFlag <= 1'b0;
      zeroFlag  <= 1'b0;
      negFlag   <= 1'b0;
    end else if (commit) begin
      if (pendUpdateFlags) begin
        zeroFlag <= (pendResult[DATA_WIDTH-1:0] == '0);
        negFlag  <= pendResult[DATA_WIDTH-1];
      end
      if (pendUpdateCarry) carryFlag <= pendResult[DATA_WIDTH];
    end
  end

  // A result offered while the stalled entry blocks capture is lost; remember it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrunError <= 1'b0;
    end else if (resultValid && !inReady) begin
      overrunError <= 1'b1;
    end
  end

  // Forward only from the captured entry, never from the raw result input
  always_comb begin
    operand1 = regs[readAddr1];
    operand2 = regs[readAddr2];
    carry    = carryFlag;
    if (pendValid && pendWriteReg && pendDest == readAddr1) operand1 = pendResult[DATA_WIDTH-1:0];
    if (pendValid && pendWriteReg && pendDest == readAddr2) operand2 = pendResult[DATA_WIDTH-1:0];
    if (pendValid && pendUpdateCarry) carry = pendResult[DATA_WIDTH];
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: forwarding, commit latency, stall/overrun,
// flag-only ops and asynchronous reset with an entry pending.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  readAddr1, readAddr2;
  logic [15:0] operand1, operand2;
  logic        carry;
  logic [16:0] result;
  logic        resultValid;
  logic [2:0]  destAddr;
  logic        writeReg, updateFlags, updateCarry, stall;
  logic        inReady, carryFlag, zeroFlag, negFlag, overrunError;

  int passCount = 0;
  int totalCount = 0;

  alu_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .readAddr1(readAddr1), .readAddr2(readAddr2),
    .operand1(operand1), .operand2(operand2), .carry(carry),
    .result(result), .resultValid(resultValid), .destAddr(destAddr),
    .writeReg(writeReg), .updateFlags(updateFlags), .updateCarry(updateCarry),
    .stall(stall), .inReady(inReady),
    .carryFlag(carryFlag), .zeroFlag(zeroFlag), .negFlag(negFlag),
    .overrunError(overrunError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [16:0] r, input logic [2:0] d,
                       input logic w, input logic f, input logic c);
    result = r; destAddr = d; writeReg = w; updateFlags = f; updateCarry = c;
    resultValid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    readAddr1 = '0; readAddr2 = '0;
    result = '0; resultValid = 1'b0; destAddr = '0;
    writeReg = 1'b0; updateFlags = 1'b0; updateCarry = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset state
    for (int i = 0; i < 8; i++) begin
      readAddr1 = 3'(i);
      #1 check($sformatf("reset_r%0d", i), operand1, 17'h0);
    end
    check("reset_carry", carry, 0);
    check("reset_zero", zeroFlag, 0);
    check("reset_inReady", inReady, 1);
    check("reset_overrun", overrunError, 0);

    // Single op, forwarded then committed
    offer(17'h10243, 3'd3, 1, 1, 1);
    tick();
    resultValid = 1'b0;
    readAddr1 = 3'd3; readAddr2 = 3'd3;
    #1;
    check("fwd_op1_r3", operand1, 17'h0243);
    check("fwd_op2_r3", operand2, 17'h0243);
    check("fwd_carry", carry, 1);
    check("precommit_C", carryFlag, 0);
    tick();
    check("commit_r3", operand1, 17'h0243);
    check("commit_C", carryFlag, 1);
    check("commit_Z", zeroFlag, 0);
    check("commit_N", negFlag, 0);

    // Back-to-back writes to R1
    offer(17'h08234, 3'd1, 1, 1, 1);
    readAddr1 = 3'd1;
    tick();
    check("b2b_first_fwd", operand1, 17'h8234);
    check("b2b_first_carry", carry, 0);
    offer(17'h00000, 3'd1, 1, 1, 1);
    tick();
    resultValid = 1'b0;
    #1;
    check("b2b_second_fwd", operand1, 17'h0000);
    check("b2b_mid_N", negFlag, 1);
    check("b2b_mid_Z", zeroFlag, 0);
    check("b2b_mid_C", carryFlag, 0);
    tick();
    check("b2b_final_r1", operand1, 17'h0000);
    check("b2b_final_Z", zeroFlag, 1);
    check("b2b_final_N", negFlag, 0);
    check("b2b_final_C", carryFlag, 0);

    // Stall with pending entry, overrun
    offer(17'h1C11A, 3'd2, 1, 1, 1);
    readAddr1 = 3'd2;
    tick();
    resultValid = 1'b0; stall = 1'b1;
    #1;
    check("stall_inReady", inReady, 0);
    check("stall_fwd_r2", operand1, 17'hC11A);
    tick();
    check("stall_Z_held", zeroFlag, 1);
    check("stall_N_held", negFlag, 0);
    check("stall_C_held", carryFlag, 0);
    offer(17'h00055, 3'd2, 1, 1, 1);
    tick();
    resultValid = 1'b0;
    #1;
    check("overrun_set", overrunError, 1);
    check("stall_pend_kept", operand1, 17'hC11A);
    check("stall_inReady2", inReady, 0);
    tick();
    stall = 1'b0;
    tick();
    check("release_r2", operand1, 17'hC11A);
    check("release_N", negFlag, 1);
    check("release_C", carryFlag, 1);
    check("release_Z", zeroFlag, 0);
    check("release_inReady", inReady, 1);
    check("overrun_sticky", overrunError, 1);

    // Register-only write leaves flags
    offer(17'h07DCA, 3'd5, 1, 0, 0);
    readAddr1 = 3'd5;
    tick();
    resultValid = 1'b0;
    #1;
    check("regonly_fwd", operand1, 17'h7DCA);
    check("regonly_carry_nofwd", carry, 1);
    tick();
    check("regonly_r5", operand1, 17'h7DCA);
    check("regonly_C", carryFlag, 1);
    check("regonly_Z", zeroFlag, 0);
    check("regonly_N", negFlag, 1);

    // Flag-only op on R5 must not touch the register
    offer(17'h00000, 3'd5, 0, 1, 0);
    tick();
    resultValid = 1'b0;
    #1;
    check("flagonly_nofwd", operand1, 17'h7DCA);
    tick();
    check("flagonly_r5", operand1, 17'h7DCA);
    check("flagonly_Z", zeroFlag, 1);
    check("flagonly_N", negFlag, 0);
    check("flagonly_C", carryFlag, 1);

    // Bubble
    offer(17'h1FFFF, 3'd5, 0, 0, 0);
    tick();
    resultValid = 1'b0;
    tick();
    check("bubble_r5", operand1, 17'h7DCA);
    check("bubble_Z", zeroFlag, 1);
    check("bubble_C", carryFlag, 1);

    // Async reset with an entry pending
    offer(17'h1046B, 3'd4, 1, 1, 1);
    readAddr1 = 3'd4; readAddr2 = 3'd5;
    tick();
    resultValid = 1'b0;
    #1;
    check("prerst_fwd_r4", operand1, 17'h046B);
    #1 rst_n = 1'b0;
    #1;
    check("rst_op1_r4", operand1, 17'h0);
    check("rst_op2_r5", operand2, 17'h0);
    check("rst_carry", carry, 0);
    check("rst_overrun", overrunError, 0);
    check("rst_Z", zeroFlag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("postrst_r4", operand1, 17'h0);
    check("postrst_C", carryFlag, 0);
    check("postrst_inReady", inReady, 1);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
